rom_gen_stream_ctrl: RTL and testbench

//  Read sequencer for the 128x16 generator ROM (1-cycle registered read, sync srst).
//  On a start command, streams word_cnt consecutive ROM words from start_addr, split into

---
 rtl/rom_gen_pkg.sv | 15 +
 rtl/rom_gen_stream_ctrl_if.sv | 27 ++
 rtl/rom_gen_skid_buf.sv | 54 +++++
 rtl/rom_gen_stream_ctrl.sv | 165 ++++++++++++++++
 tb/tb_rom_gen_stream_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rom_gen_pkg.sv
// Shared constants and FSM state type for the generator-ROM stream controller.
package rom_gen_pkg;

  localparam int unsigned ROM_AW = 7;   // ROM address width (128 words)
  localparam int unsigned ROM_DW = 16;  // ROM word width
  localparam int unsigned BEAT_W = 8;   // output beat width
  localparam int unsigned CNT_W  = 8;   // job word-count width

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

endpackage

// File: rtl/rom_gen_stream_ctrl_if.sv
// Byte-wide valid/ready stream carrying the ROM words out of the controller.
interface rom_gen_stream_ctrl_if
  import rom_gen_pkg::*;
#(
  parameter int unsigned BW = BEAT_W
);

  logic          m_valid;
  logic [BW-1:0] m_data;
  logic          m_last;
  logic          m_ready;

  modport master (
    output m_valid,
    output m_data,
    output m_last,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_data,
    input  m_last,
    output m_ready
  );

endinterface

// File: rtl/rom_gen_skid_buf.sv
// Two-entry word FIFO that absorbs ROM read latency and downstream stalls.
// Pushes into a full buffer and pops from an empty one are ignored.
module rom_gen_skid_buf
  import rom_gen_pkg::*;
#(
  parameter int unsigned DW = ROM_DW
)(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] head,
  output logic [1:0]    occ
);

  logic [DW-1:0] mem [2];
  logic          wr_ptr;
  logic          rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Qualify requests against current fill level.
  always_comb begin
    do_push = push && ((occ != 2'd2) || pop);
    do_pop  = pop && (occ != 2'd0);
    head    = mem[rd_ptr];
  end

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: rtl/rom_gen_stream_ctrl.sv
// Read sequencer for the 128x16 generator ROM: on start, streams word_cnt words
// from start_addr as bytes (high byte first) over a valid/ready master port.
// Optional build macro ROM_STREAM_PERF_EN adds the stall_cnt back-pressure counter.
module rom_gen_stream_ctrl
  import rom_gen_pkg::*;
#(
  parameter int unsigned AW = ROM_AW,
  parameter int unsigned DW = ROM_DW,
  parameter int unsigned BW = BEAT_W,
  parameter int unsigned CW = CNT_W
)(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [AW-1:0]         start_addr,
  input  logic [CW-1:0]         word_cnt,
  output logic                  busy,
  output logic                  done,
  output logic                  rom_srst,
  output logic [AW-1:0]         rom_addr,
  input  logic [DW-1:0]         rom_dout,
  rom_gen_stream_ctrl_if.master m
`ifdef ROM_STREAM_PERF_EN
  ,
  output logic [15:0]           stall_cnt
`endif
);

  state_t        state;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] issued_q;
  logic [CW-1:0] words_out_q;
  logic          inflight_q;
  logic          byte_sel_q;

  logic [1:0]    occ;
  logic [DW-1:0] fifo_head;
  logic [DW-1:0] cur_word;
  logic          out_valid;
  logic          fire;
  logic          last_word;
  logic          last_beat;
  logic          issue;
  logic          pop;

  rom_gen_skid_buf #(
    .DW (DW)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight_q),
    .push_data (rom_dout),
    .pop       (pop),
    .head      (fifo_head),
    .occ       (occ)
  );

  // Output word selection, handshake and issue decisions.
  // An empty buffer with a word in flight presents rom_dout directly so the
  // first beat appears the cycle the ROM data does; that word is pushed into
  // the buffer the same cycle, so a stall leaves it stable as the new head.
  always_comb begin
    out_valid = (occ != 2'd0) || inflight_q;
    cur_word  = (occ != 2'd0) ? fifo_head : rom_dout;
    last_word = (words_out_q == (cnt_q - CW'(1)));
    last_beat = out_valid && byte_sel_q && last_word;
    fire      = out_valid && m.m_ready;
    pop       = fire && byte_sel_q;
    issue     = (state == ST_RUN) && (issued_q != cnt_q) &&
                ((occ + {1'b0, inflight_q}) < 2'd2);
  end

  // Drive the stream port; data and last are forced low while idle.
  always_comb begin
    m.m_valid = out_valid;
    m.m_data  = '0;
    if (out_valid) begin
      m.m_data = byte_sel_q ? cur_word[BW-1:0] : cur_word[DW-1 -: BW];
    end
    m.m_last  = last_beat;
  end

  // Job FSM with address/issue counters, in-flight flag and byte select.
  // An empty job spends two cycles in DONE (busy then done) so its done pulse
  // lands two cycles after the start strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      rom_srst    <= 1'b1;
      rom_addr    <= '0;
      cnt_q       <= '0;
      issued_q    <= '0;
      words_out_q <= '0;
      inflight_q  <= 1'b0;
      byte_sel_q  <= 1'b0;
    end else begin
      inflight_q <= issue;
      case (state)
        ST_IDLE: begin
          if (start) begin
            cnt_q       <= word_cnt;
            issued_q    <= '0;
            words_out_q <= '0;
            byte_sel_q  <= 1'b0;
            busy        <= 1'b1;
            rom_srst    <= 1'b0;
            if (word_cnt == '0) begin
              state <= ST_DONE;
            end else begin
              state    <= ST_RUN;
              rom_addr <= start_addr;
            end
          end
        end
        ST_RUN: begin
          if (issue) begin
            rom_addr <= rom_addr + AW'(1);
            issued_q <= issued_q + CW'(1);
          end
          if (fire) begin
            byte_sel_q <= ~byte_sel_q;
            if (byte_sel_q) begin
              words_out_q <= words_out_q + CW'(1);
            end
          end
          if (fire && last_beat) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        ST_DONE: begin
          if (done) begin
            done     <= 1'b0;
            rom_srst <= 1'b1;
            state    <= ST_IDLE;
          end else begin
            done <= 1'b1;
            busy <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef ROM_STREAM_PERF_EN
  // Count RUN cycles where a beat is offered but not taken; saturating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= 16'h0000;
    end else if ((state == ST_IDLE) && start) begin
      stall_cnt <= 16'h0000;
    end else if ((state == ST_RUN) && out_valid && !m.m_ready &&
                 (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rom_gen_stream_ctrl.sv
// Self-checking bench for rom_gen_stream_ctrl: ROM model, beat-queue reference
// model checked every cycle, plus directed jobs with literal expectations.
module tb_rom_gen_stream_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [6:0]  start_addr = '0;
  logic [7:0]  word_cnt = '0;
  logic        busy;
  logic        done;
  logic        rom_srst;
  logic [6:0]  rom_addr;
  logic [15:0] rom_dout;
`ifdef ROM_STREAM_PERF_EN
  logic [15:0] stall_cnt;
`endif

  rom_gen_stream_ctrl_if #(.BW(8)) m_if ();

  rom_gen_stream_ctrl #(
    .AW (7),
    .DW (16),
    .BW (8),
    .CW (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .start_addr (start_addr),
    .word_cnt   (word_cnt),
    .busy       (busy),
    .done       (done),
    .rom_srst   (rom_srst),
    .rom_addr   (rom_addr),
    .rom_dout   (rom_dout),
    .m          (m_if)
`ifdef ROM_STREAM_PERF_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ROM content: word a holds bytes 2a (high) and 2a+1 (low).
  function automatic logic [15:0] rom_fn(input logic [6:0] a);
    return {a, 1'b0, a, 1'b1};
  endfunction

  // 1-cycle registered ROM with synchronous reset.
  always @(posedge clk) rom_dout <= rom_srst ? 16'h0000 : rom_fn(rom_addr);

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Ready driver: 0 = always ready, 1 = random, 2 = never ready.
  int rdy_mode = 0;
  initial begin
    m_if.m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       m_if.m_ready = 1'b1;
        1:       m_if.m_ready = 1'($urandom_range(0, 1));
        default: m_if.m_ready = 1'b0;
      endcase
    end
  end

  // Reference model state.
  logic [7:0] exp_data[$];
  logic       exp_last[$];
  int         due = 0;
  bit         job_active = 0;
  bit         prev_stall = 0;
  logic [7:0] prev_data;
  logic       prev_last;
  bit         prev_busy = 0;
  logic [6:0] prev_addr;
  int         incs = 0;
  int         completed = 0;

  // Observation logs for the directed literal checks.
  logic [7:0] log_data[$];
  int         log_cyc[$];
  logic       log_last[$];
  int         first_valid_cyc = -1;
  int         done_cyc = -1;

  // Per-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_data.delete();
      exp_last.delete();
      due        = 0;
      job_active = 0;
      prev_stall = 0;
      prev_busy  = 0;
      incs       = 0;
      completed  = 0;
    end else begin
      bit exp_done;
      exp_done = (due == 1);
      chk("done", done, exp_done);
      chk("busy", busy, job_active && !exp_done);
      chk("rom_srst", rom_srst, !job_active);
      if (done) done_cyc = cyc;
      if (due != 0) due--;

      if (start && !job_active) begin
        job_active = 1;
        incs       = 0;
        completed  = 0;
        for (int i = 0; i < int'(word_cnt); i++) begin
          logic [6:0]  a;
          logic [15:0] w;
          a = start_addr + 7'(i);
          w = rom_fn(a);
          exp_data.push_back(w[15:8]);
          exp_last.push_back(1'b0);
          exp_data.push_back(w[7:0]);
          exp_last.push_back(i == int'(word_cnt) - 1);
        end
        if (word_cnt == 8'd0) due = 2;
      end
      if (exp_done) job_active = 0;

      if (prev_stall) begin
        chk("stall_valid", m_if.m_valid, 1'b1);
        chk("stall_data", m_if.m_data, prev_data);
        chk("stall_last", m_if.m_last, prev_last);
      end

      if (busy && prev_busy && (rom_addr != prev_addr)) incs++;
      chk("issue_ahead", (incs - completed) <= 2, 1'b1);

      if (m_if.m_valid) begin
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
        if (exp_data.size() == 0) begin
          chk("spurious_valid", m_if.m_valid, 1'b0);
        end else begin
          chk("m_data", m_if.m_data, exp_data[0]);
          chk("m_last", m_if.m_last, exp_last[0]);
          if (m_if.m_ready) begin
            log_data.push_back(m_if.m_data);
            log_cyc.push_back(cyc);
            log_last.push_back(m_if.m_last);
            if (exp_data.size() % 2 == 1) completed++;
            if (exp_last[0]) due = 1;
            void'(exp_data.pop_front());
            void'(exp_last.pop_front());
          end
        end
      end

      prev_stall = m_if.m_valid && !m_if.m_ready;
      prev_data  = m_if.m_data;
      prev_last  = m_if.m_last;
      prev_busy  = busy;
      prev_addr  = rom_addr;
    end
  end

  task automatic clear_logs();
    log_data.delete();
    log_cyc.delete();
    log_last.delete();
    first_valid_cyc = -1;
    done_cyc = -1;
  endtask

  task automatic launch(input logic [6:0] a, input logic [7:0] n, output int t);
    @(posedge clk);
    #1;
    start      = 1'b1;
    start_addr = a;
    word_cnt   = n;
    t          = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && done_cyc < 0; i++) begin
      @(negedge clk);
      #1;
    end
    chk("done_seen", done_cyc >= 0, 1'b1);
    @(negedge clk);
    #1;
  endtask

  task automatic check_beats(input string name, input logic [7:0] first, input int n);
    chk({name, "_count"}, log_data.size(), n);
    if (log_data.size() == n) begin
      for (int i = 0; i < n; i++) begin
        chk({name, "_data"}, log_data[i], first + 8'(i));
        chk({name, "_last"}, log_last[i], i == n - 1);
      end
    end
  endtask

  task automatic check_reset_vals(input string name);
    chk({name, "_busy"}, busy, 1'b0);
    chk({name, "_done"}, done, 1'b0);
    chk({name, "_srst"}, rom_srst, 1'b1);
    chk({name, "_addr"}, rom_addr, 7'h00);
    chk({name, "_valid"}, m_if.m_valid, 1'b0);
    chk({name, "_data"}, m_if.m_data, 8'h00);
    chk({name, "_last"}, m_if.m_last, 1'b0);
  endtask

  initial begin
    #20000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         t;
    logic [6:0] saved_addr;

    repeat (3) @(negedge clk);
    check_reset_vals("reset");
`ifdef ROM_STREAM_PERF_EN
    chk("reset_stall_cnt", stall_cnt, 16'h0000);
`endif
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: two words from 0x00, always ready.
    clear_logs();
    launch(7'h00, 8'd2, t);
    wait_done(40);
    check_beats("t1", 8'h00, 4);
    chk("t1_first_valid_lat", first_valid_cyc - t, 2);
    if (log_cyc.size() == 4) chk("t1_done_lat", done_cyc - log_cyc[3], 1);

    // 2: address wrap 0x7F -> 0x00.
    clear_logs();
    launch(7'h7F, 8'd2, t);
    wait_done(40);
    chk("t2_count", log_data.size(), 4);
    if (log_data.size() == 4) begin
      chk("t2_b0", log_data[0], 8'hFE);
      chk("t2_b1", log_data[1], 8'hFF);
      chk("t2_b2", log_data[2], 8'h00);
      chk("t2_b3", log_data[3], 8'h01);
    end

    // 3: random back-pressure.
    rdy_mode = 1;
    clear_logs();
    launch(7'h10, 8'd4, t);
    wait_done(400);
    check_beats("t3", 8'h20, 8);
    rdy_mode = 0;

    // 4: empty job.
    saved_addr = rom_addr;
    clear_logs();
    launch(7'h55, 8'd0, t);
    wait_done(20);
    chk("t4_done_lat", done_cyc - t, 2);
    chk("t4_no_valid", first_valid_cyc, -1);
    chk("t4_addr_kept", rom_addr, saved_addr);

    // 5: start while busy is ignored.
    clear_logs();
    launch(7'h30, 8'd3, t);
    launch(7'h40, 8'd5, t);
    wait_done(60);
    check_beats("t5", 8'h60, 6);

    // 6: asynchronous reset mid-job, then a fresh job.
    clear_logs();
    launch(7'h00, 8'd8, t);
    for (int i = 0; i < 50 && log_data.size() < 3; i++) begin
      @(negedge clk);
      #1;
    end
    chk("t6_beats_before_rst", log_data.size() >= 3, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("t6_async");
    done_cyc = -1;
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    #1;
    chk("t6_no_done", done_cyc, -1);
    clear_logs();
    launch(7'h20, 8'd1, t);
    wait_done(40);
    check_beats("t6_after", 8'h40, 2);

`ifdef ROM_STREAM_PERF_EN
    // Five stalled cycles while a beat is offered.
    rdy_mode = 2;
    clear_logs();
    launch(7'h00, 8'd4, t);
    for (int i = 0; i < 20 && !m_if.m_valid; i++) begin
      @(negedge clk);
      #1;
    end
    chk("perf_valid_seen", m_if.m_valid, 1'b1);
    repeat (4) @(negedge clk);
    rdy_mode = 0;
    wait_done(60);
    chk("perf_stall_cnt", stall_cnt, 16'd5);
    check_beats("perf", 8'h00, 8);
`endif

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
